// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default widths for the SCLK generator.
package spi_pkg;

    localparam int DIV_W_DEF  = 8;
    localparam int NPER_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sclk_state_e;

endpackage

// File: rtl/spi_div_cnt.sv
// Half-period counter: counts clk_in cycles up to div_q and pulses tc on the terminal count.
module spi_div_cnt #(
    parameter int DIV_W = spi_pkg::DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div_q,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = en && (cnt == div_q);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: emits a burst of divided clock periods with edge strobes,
// either a fixed count or continuous until stop.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int NPER_W = NPER_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    input  logic [NPER_W-1:0] nper,
    input  logic              cpol,
    output logic              clk_out,
    output logic              lead_stb,
    output logic              trail_stb,
    output logic              busy,
    output logic              done
);

    sclk_state_e       state, state_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [NPER_W-1:0] nper_q, nper_n;
    logic              cpol_q, cpol_n;
    logic [NPER_W:0]   edge_cnt, edge_n, edge_inc, edge_end;
    logic              fin, fin_n;
    logic              stop_pend, stop_n;
    logic              clk_n, lead_n, trail_n;
    logic              tc;

    assign edge_inc = edge_cnt + (NPER_W + 1)'(1);
    assign edge_end = {nper_q, 1'b0};
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // fin marks that the final trailing edge has been emitted; the counter freezes
    // so the DONE cycle follows the last trail_stb with no further toggles.
    spi_div_cnt #(.DIV_W(DIV_W)) u_div_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (state != RUN),
        .en     ((state == RUN) && !fin),
        .div_q  (div_q),
        .tc     (tc)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_q     <= '0;
            nper_q    <= '0;
            cpol_q    <= 1'b0;
            edge_cnt  <= '0;
            fin       <= 1'b0;
            stop_pend <= 1'b0;
            clk_out   <= 1'b0;
            lead_stb  <= 1'b0;
            trail_stb <= 1'b0;
        end else begin
            state     <= state_n;
            div_q     <= div_n;
            nper_q    <= nper_n;
            cpol_q    <= cpol_n;
            edge_cnt  <= edge_n;
            fin       <= fin_n;
            stop_pend <= stop_n;
            clk_out   <= clk_n;
            lead_stb  <= lead_n;
            trail_stb <= trail_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_q;
        nper_n  = nper_q;
        cpol_n  = cpol_q;
        edge_n  = edge_cnt;
        fin_n   = fin;
        stop_n  = stop_pend;
        clk_n   = clk_out;
        lead_n  = 1'b0;
        trail_n = 1'b0;
        case (state)
            IDLE: begin
                clk_n = cpol;
                if (start) begin
                    state_n = RUN;
                    div_n   = div;
                    nper_n  = nper;
                    cpol_n  = cpol;
                    edge_n  = '0;
                    fin_n   = 1'b0;
                    stop_n  = 1'b0;
                end
            end
            RUN: begin
                if (fin) begin
                    state_n = DONE;
                end else begin
                    if (stop) stop_n = 1'b1;
                    if (tc) begin
                        clk_n  = ~clk_out;
                        edge_n = edge_inc;
                        if (edge_inc[0]) begin
                            lead_n = 1'b1;
                        end else begin
                            trail_n = 1'b1;
                            // Stop only takes effect on a trailing edge, so no runt phase.
                            if (stop || stop_pend || ((nper_q != '0) && (edge_inc == edge_end)))
                                fin_n = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                clk_n   = cpol_q;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                clk_n   = cpol;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: table of bursts plus hand sequences for stop and reset.
module tb_spi_sclk_gen;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div = '0;
    logic [3:0] nper = '0;
    logic       cpol = 1'b0;
    logic       clk_out, lead_stb, trail_stb, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    spi_sclk_gen #(.DIV_W(8), .NPER_W(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .nper      (nper),
        .cpol      (cpol),
        .clk_out   (clk_out),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] div;
        logic [3:0] nper;
        logic       cpol;
        bit         disturb;
        int         exp_tog;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v, input int id);
        string tag;
        int k, tog, leads, last, last_trail, bad, done_k, extra, ival;
        bit got_done;
        logic prev, clk_at_done;
        tag = $sformatf("v%0d", id);
        div = v.div; nper = v.nper; cpol = v.cpol; start = 1'b0; stop = 1'b0;
        tick();
        chk({tag, "_idle_lvl"}, clk_out, v.cpol);
        chk({tag, "_idle_busy"}, busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_up"}, busy, 1);
        chk({tag, "_lvl_at_start"}, clk_out, v.cpol);
        k = 0; tog = 0; leads = 0; last = 0; last_trail = -1; bad = 0;
        done_k = -1; got_done = 0; clk_at_done = 1'bx;
        for (int c = 0; c < 20000 && !got_done; c++) begin
            prev = clk_out;
            tick();
            k++;
            if (v.disturb && k == 5) begin
                start = 1'b1; div = 8'd7; nper = 4'd9; cpol = ~v.cpol;
            end else if (v.disturb && k == 6) begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1; done_k = k; clk_at_done = clk_out;
            end else if (clk_out !== prev) begin
                tog++;
                ival = (tog == 1) ? k : k - last;
                if (ival != int'(v.div) + 1) bad++;
                last = k;
                if (clk_out !== v.cpol) begin
                    leads++;
                    if (!lead_stb || trail_stb) bad++;
                end else begin
                    last_trail = k;
                    if (!trail_stb || lead_stb) bad++;
                end
            end else if (lead_stb || trail_stb) begin
                bad++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_toggles"}, tog, v.exp_tog);
        chk({tag, "_leads"}, leads, v.exp_tog / 2);
        chk({tag, "_timing_errs"}, bad, 0);
        chk({tag, "_done_after_trail"}, done_k, last_trail + 1);
        chk({tag, "_lvl_at_done"}, clk_at_done, v.cpol);
        tick();
        chk({tag, "_busy_down"}, busy, 0);
        extra = 0;
        repeat (4) begin
            if (done) extra++;
            tick();
        end
        chk({tag, "_single_done"}, extra, 0);
        div = v.div; nper = v.nper; cpol = v.cpol;
    endtask

    initial begin
        int k, tog, leads, extra;
        logic prev;
        bit got;
        vecs[0] = '{div: 8'd0,   nper: 4'd2,  cpol: 1'b0, disturb: 0, exp_tog: 4};
        vecs[1] = '{div: 8'd2,   nper: 4'd1,  cpol: 1'b1, disturb: 0, exp_tog: 2};
        vecs[2] = '{div: 8'd3,   nper: 4'd2,  cpol: 1'b0, disturb: 1, exp_tog: 4};
        vecs[3] = '{div: 8'd255, nper: 4'd15, cpol: 1'b0, disturb: 0, exp_tog: 30};
        vecs[4] = '{div: 8'd0,   nper: 4'd1,  cpol: 1'b1, disturb: 0, exp_tog: 2};
        vecs[5] = '{div: 8'd5,   nper: 4'd3,  cpol: 1'b1, disturb: 0, exp_tog: 6};
        vecs[6] = '{div: 8'd1,   nper: 4'd4,  cpol: 1'b0, disturb: 1, exp_tog: 8};

        // Reset state, with cpol=1 on the input to show reset forces clk_out low.
        cpol = 1'b1;
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {lead_stb, trail_stb}, 0);
        tick(); tick();
        chk("rst_held_clk_out", clk_out, 0);
        rst = 1'b0;
        tick();
        chk("idle_follows_cpol", clk_out, 1);

        for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

        // Continuous burst ended by stop pulsed during a high phase.
        div = 8'd1; nper = 4'd0; cpol = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        leads = 0; k = 0;
        for (int c = 0; c < 200 && leads < 3; c++) begin
            prev = clk_out;
            tick();
            k++;
            if (clk_out && !prev) leads++;
        end
        chk("stop_third_lead_k", k, 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_high_holds", {clk_out, trail_stb, done}, 3'b100);
        tick();
        chk("stop_trail_edge", {clk_out, trail_stb, done}, 3'b010);
        tick();
        chk("stop_done", {clk_out, done, busy}, 3'b011);
        tick();
        chk("stop_idle", {busy, done}, 0);
        tog = 0;
        repeat (10) begin
            prev = clk_out;
            tick();
            if (clk_out !== prev || lead_stb || trail_stb) tog++;
        end
        chk("stop_no_more_toggles", tog, 0);

        // Start and stop together in IDLE: start wins, burst is continuous.
        div = 8'd0; nper = 4'd0; cpol = 1'b0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tog = 0;
        repeat (20) begin
            prev = clk_out;
            tick();
            if (clk_out !== prev) tog++;
        end
        chk("startstop_toggles", tog, 20);
        chk("startstop_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else tick();
        end
        chk("startstop_done", got, 1);
        chk("startstop_done_lvl", clk_out, 0);
        tick(); tick();

        // Reset mid-burst.
        div = 8'd4; nper = 4'd8; cpol = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_async", {clk_out, busy, lead_stb, trail_stb, done}, 0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("midrst_cpol_after", clk_out, 1);
        extra = 0;
        repeat (60) begin
            if (done || busy) extra++;
            tick();
        end
        chk("midrst_no_done", extra, 0);
        run_burst('{div: 8'd4, nper: 4'd2, cpol: 1'b1, disturb: 0, exp_tog: 4}, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the half-period divisor.
REQ-002 SHALL have parameter NPER_W, default 4, width of the burst period count.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  request to end a continuous burst; sampled only in RUN.
REQ-007 SHALL have port div  input  DIV_W  half-period is div+1 clk_in cycles; latched at accepted start.
REQ-008 SHALL have port nper  input  NPER_W  number of full clk_out periods; 0 = continuous until stop; latched at accepted start.
REQ-009 SHALL have port cpol  input  1  idle level of clk_out; latched at accepted start.
REQ-010 SHALL have port clk_out  output  1  divided clock, registered.
REQ-011 SHALL have port lead_stb  output  1  high in the cycle clk_out first takes its non-idle level in each period.
REQ-012 SHALL have port trail_stb  output  1  high in the cycle clk_out returns to its idle level.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on final trailing edge; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL, in IDLE, register clk_out <= cpol every cycle; strobes low.
REQ-017 SHALL, on accepted start, latch div, nper, cpol and clear the half-period counter and edge counter.
REQ-018 SHALL toggle clk_out when the half-period counter equals div_q, then reset the counter to 0; the first toggle is visible div+1 cycles after the clock edge that sampled start.
REQ-019 SHALL count toggles in an NPER_W+1-bit edge counter; odd toggles are leading (lead_stb), even toggles are trailing (trail_stb).
REQ-020 SHALL, for nper!=0, end the burst at trailing edge number nper (toggle 2*nper); no further toggles follow.
REQ-021 SHALL, for nper=0, run indefinitely, with the edge counter allowed to wrap without effect.
REQ-022 SHALL, on stop in RUN, end at the next trailing edge; a stop coinciding with a trailing edge ends at that edge; clk_out never produces a runt phase.
REQ-023 SHALL assert done and hold clk_out at cpol_q in DONE; busy falls in the cycle after done.
REQ-024 SHALL ignore start while busy, stop while IDLE or DONE, and changes to div/nper/cpol while busy.
REQ-025 SHALL give start priority when start and stop are both high in IDLE; stop is then ignored.
REQ-026 SHALL operate for div=0 (clk_out = clk_in/2) through div=2^DIV_W-1.

Reset
REQ-027 SHALL on rst force IDLE, clk_out=0, lead_stb=0, trail_stb=0, busy=0, done=0, all counters and latched fields 0, asynchronously and regardless of state.
REQ-028 SHALL, after a mid-burst reset, emit no done, and SHALL drive clk_out to cpol from the first clk_in edge after rst falls.

Structure
REQ-029 SHALL take the state encoding (IDLE=0, RUN=1, DONE=2) and default parameter values from the shared spi_pkg package.
REQ-030 SHALL place the half-period counter (clear, compare to div_q, terminal pulse) in sub-module spi_div_cnt; FSM, edge counter and strobes stay in spi_sclk_gen.

Verification
REQ-031 SHALL cover: div=0, nper=2, cpol=0, start -> clk_out 0->1 one cycle later, period 2 cycles, 4 toggles, lead_stb x2, trail_stb x2, done one cycle after the last trail_stb.
REQ-032 SHALL cover: div=2, nper=1, cpol=1 -> clk_out idles 1, falls 3 cycles after start (lead_stb), rises 3 cycles later (trail_stb), then done, then busy=0.
REQ-033 SHALL cover: div=1, nper=0, stop during a high phase -> high phase completes, clk_out falls with trail_stb, then done; no further toggles.
REQ-034 SHALL cover: start again plus div changed to 7 during a div=3 burst -> ignored; half-period stays 4 cycles; exactly one done.
REQ-035 SHALL cover: rst pulsed mid-burst (div=4, nper=8) -> clk_out, busy, strobes 0 immediately, no done; a following start runs normally.
REQ-036 SHALL cover: div=255, nper=15 -> exactly 30 toggles, each half-period 256 cycles, done once.
